// File: rtl/lcd_bus_writer.sv
// -----------------------------------------------------------------------------
// lcd_bus_writer
//
// Purpose:
//   This block sits after the LCD 9-bit command/data bus mux. It accepts one
//   word {dc, data[7:0]} per valid/ready handshake. For each word it runs one
//   8080-style parallel write cycle on the LCD pins (CS_n, DC, WR_n, D[7:0]).
//   The setup, strobe-low and hold phases each last a parameterised number of
//   clock cycles. Only one write is in flight at a time.
//
// Parameters:
//   SETUP_CYC  - cycles with CS_n low and DC/D valid before WR_n falls (>=1)
//   WR_LOW_CYC - cycles WR_n is held low (>=1)
//   HOLD_CYC   - cycles after WR_n rises with CS_n/DC/D still held (>=1)
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset_n    in   1  asynchronous assert, active-low reset
//   wr_word    in   9  [8]=dc (0 command, 1 data), [7:0]=byte
//   wr_valid   in   1  wr_word is valid
//   wr_ready   out  1  writer can accept a word (IDLE only)
//   lcd_cs_n   out  1  LCD chip select, active low
//   lcd_dc     out  1  LCD data/command select
//   lcd_wr_n   out  1  LCD write strobe, active low, data latched on rise
//   lcd_rd_n   out  1  LCD read strobe, tied high (write-only interface)
//   lcd_data   out  8  LCD data bus
//   busy       out  1  a write cycle is in progress
//   done_tick  out  1  one-cycle pulse in the first IDLE cycle after a write
//
// Timing (accept at edge E):
//   CS_n low from E+1.
//   WR_n low from E+1+SETUP_CYC for WR_LOW_CYC cycles.
//   CS_n high and done_tick at E+1+SETUP_CYC+WR_LOW_CYC+HOLD_CYC.
// -----------------------------------------------------------------------------
module lcd_bus_writer #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned WR_LOW_CYC = 3,
    parameter int unsigned HOLD_CYC   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [8:0] wr_word,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic       lcd_cs_n,
    output logic       lcd_dc,
    output logic       lcd_wr_n,
    output logic       lcd_rd_n,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       done_tick
);

    // The phase counter is sized for the longest phase. Each phase loads
    // (cycles-1) on entry and counts down to zero.
    localparam int unsigned MAX_AB  = (SETUP_CYC > WR_LOW_CYC) ? SETUP_CYC : WR_LOW_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LOAD    = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cs_n_q, cs_n_d;
    logic             wr_n_q, wr_n_d;
    logic             dc_q, dc_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             accept;

    // The writer is ready only in IDLE. That includes the done_tick cycle,
    // so back-to-back words lose only that single cycle.
    assign accept = wr_valid && (state_q == ST_IDLE);

    // -------------------------------------------------------------------------
    // Next-state, counter and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dc_d    = dc_q;
        data_d  = data_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                    // DC and data change only when a word is accepted.
                    // CS_n is still high at that point, so the LCD never
                    // sees DC move inside a selected cycle.
                    dc_d    = wr_word[8];
                    data_d  = wr_word[7:0];
                end
            end

            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = WR_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // The pin levels are decoded from the state being entered and then
        // registered. This keeps the pins glitch-free and in step with the
        // state register.
        cs_n_d = (state_d == ST_IDLE);
        wr_n_d = (state_d != ST_STROBE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            dc_q    <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            dc_q    <= dc_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign wr_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign lcd_cs_n  = cs_n_q;
    assign lcd_wr_n  = wr_n_q;
    assign lcd_dc    = dc_q;
    assign lcd_data  = data_q;
    assign done_tick = done_q;
    assign lcd_rd_n  = 1'b1;

endmodule
